orion_mem_arbiter: RTL and testbench
====================================

ORION_MEM_ARBITER -- requirements
Module: orion_mem_arbiter

Interface
REQ-001 Parameter: STARVE_LIMIT, default 4, max consecutive D-side grants while an I-side request waits (range 1..15).
REQ-002 clk_i  in  1  single clock; all state on rising edge.
REQ-003 rst_ni  in  1  reset, asynchronous, active-low.
REQ-004 imem_addr_i  in  ADDRW  fetch address.
REQ-005 imem_valid_i  in  1  fetch request, level-held until imem_resp_o or flush.
REQ-006 imem_rdata_o  out  XLEN  fetch read data, valid with imem_resp_o.
REQ-007 imem_resp_o  out  1  one-cycle fetch completion pulse.
REQ-008 dmem_addr_i / dmem_wdata_i / dmem_mask_i / dmem_we_i  in  ADDRW/XLEN/MASKW/1  data request fields.
REQ-009 dmem_valid_i  in  1  data request, level-held until dmem_resp_o.
REQ-010 dmem_rdata_o  out  XLEN  load data, valid with dmem_resp_o.
REQ-011 dmem_resp_o  out  1  one-cycle data completion pulse.
REQ-012 mem_addr_o / mem_wdata_o / mem_mask_o / mem_we_o  out  ADDRW/XLEN/MASKW/1  shared-port request fields.
REQ-013 mem_valid_o  out  1  shared-port request valid.
REQ-014 mem_rdata_i  in  XLEN  shared-port read data.
REQ-015 mem_resp_i  in  1  shared-port completion pulse.

Function
REQ-016 FSM states IDLE, IBUSY, DBUSY; reset state IDLE.
REQ-017 IDLE: dmem_valid_i=1 -> DBUSY, unless imem_valid_i=1 and starve count = STARVE_LIMIT, then IBUSY.
REQ-018 IDLE: only imem_valid_i=1 -> IBUSY; neither -> stay IDLE.
REQ-019 On grant, addr/wdata/mask/we of winner SHALL be latched into holding registers; I-side latches we=0, mask=all-ones, wdata=0.
REQ-020 mem_valid_o and mem_* fields SHALL be driven from registers only: high from the cycle after grant through the mem_resp_i cycle inclusive; latency request->mem_valid_o = 1 cycle.
REQ-021 mem_resp_i in IBUSY/DBUSY SHALL be routed combinationally, same cycle, to the owner's resp_o and rdata_o; FSM -> IDLE next cycle.
REQ-022 mem_resp_i in the first mem_valid_o cycle SHALL be accepted (1-cycle memory).
REQ-023 Non-owner resp_o SHALL be 0; both rdata_o SHALL equal mem_rdata_i at all times.
REQ-024 mem_resp_i in IDLE SHALL be ignored; no resp_o asserted.
REQ-025 Flush: imem_valid_i dropping during IBUSY SHALL NOT abort the port transaction; an abort flag is set and the completing imem_resp_o suppressed; flag cleared on leaving IBUSY.
REQ-026 Starve counter (4 bit): +1 on D grant with imem_valid_i=1, saturating at STARVE_LIMIT; cleared on I grant or on D grant with imem_valid_i=0.
REQ-027 Request fields changing while owner is busy SHALL NOT affect mem_* outputs.
REQ-028 Back-to-back: requester seeing resp in cycle N and holding valid in N+1 SHALL be regranted; earliest next mem_valid_o at N+2.

Reset
REQ-029 rst_ni low SHALL immediately force IDLE, mem_valid_o=0, all mem_* fields 0, resp_o=0, starve count 0, abort flag 0.
REQ-030 Reset mid-transaction SHALL discard the outstanding request; no resp_o after release.

Structure
REQ-031 ADDRW, XLEN, MASKW and enum arb_state_e SHALL live in package orion_types.
REQ-032 No sub-module; single flat module, placed between orion_core's imem/dmem ports and the memory.

Verification
REQ-033 dmem_valid_i=1, we=0, addr 0x100; mem_resp_i 3 cycles later, rdata 0xDEADBEEF -> dmem_resp_o one pulse, dmem_rdata_o=0xDEADBEEF, imem_resp_o=0.
REQ-034 Both valid same cycle, STARVE_LIMIT=4, memory 1-cycle -> grant order D,D,D,D,I; imem_resp_o on 5th completion.
REQ-035 IBUSY at 0x40, imem_valid_i dropped next cycle, mem_resp_i 2 cycles later -> no imem_resp_o; next IDLE grants pending D request.
REQ-036 dmem write 0x200, wdata 0x12345678, mask 0b0011; dmem_addr_i changed to 0x300 mid-transaction -> mem_addr_o stays 0x200, mem_we_o=1, mem_mask_o=0b0011.
REQ-037 rst_ni low during DBUSY, mem_resp_i pulsed after release -> no resp_o, mem_valid_o=0 asynchronously, FSM IDLE.
REQ-038 mem_resp_i pulsed in IDLE with no requests -> all resp_o stay 0, state unchanged.

Source files
------------

// File: rtl/orion_mem_arbiter_pkg.sv
// Shared types and widths for the orion memory arbiter.
package orion_types;

    localparam int ADDRW = 32;
    localparam int XLEN  = 32;
    localparam int MASKW = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        IBUSY = 2'd1,
        DBUSY = 2'd2
    } arb_state_e;

endpackage

// File: rtl/orion_mem_arbiter.sv
// Two-requester arbiter sharing one memory port between instruction fetch
// and data access. Data side has priority, bounded by a starvation limit.
//
// state | meaning
// IDLE  | no port owner; arbitration happens here
// IBUSY | fetch owns the port, waiting for mem_resp_i
// DBUSY | data side owns the port, waiting for mem_resp_i
module orion_mem_arbiter
    import orion_types::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [ADDRW-1:0] imem_addr_i,
    input  logic             imem_valid_i,
    output logic [XLEN-1:0]  imem_rdata_o,
    output logic             imem_resp_o,
    input  logic [ADDRW-1:0] dmem_addr_i,
    input  logic [XLEN-1:0]  dmem_wdata_i,
    input  logic [MASKW-1:0] dmem_mask_i,
    input  logic             dmem_we_i,
    input  logic             dmem_valid_i,
    output logic [XLEN-1:0]  dmem_rdata_o,
    output logic             dmem_resp_o,
    output logic [ADDRW-1:0] mem_addr_o,
    output logic [XLEN-1:0]  mem_wdata_o,
    output logic [MASKW-1:0] mem_mask_o,
    output logic             mem_we_o,
    output logic             mem_valid_o,
    input  logic [XLEN-1:0]  mem_rdata_i,
    input  logic             mem_resp_i
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    arb_state_e       state_q, state_d;
    logic [3:0]       starve_q, starve_d;
    logic             abort_q, abort_d;
    logic             mem_valid_q, mem_valid_d;
    logic [ADDRW-1:0] addr_q;
    logic [XLEN-1:0]  wdata_q;
    logic [MASKW-1:0] mask_q;
    logic             we_q;
    logic             grant_i, grant_d;

    // Arbitration, completion tracking, starvation count and flush flag.
    always_comb begin
        state_d     = state_q;
        grant_i     = 1'b0;
        grant_d     = 1'b0;
        starve_d    = starve_q;
        abort_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (dmem_valid_i && !(imem_valid_i && starve_q == LIMIT)) begin
                    state_d = DBUSY;
                    grant_d = 1'b1;
                end else if (imem_valid_i) begin
                    state_d = IBUSY;
                    grant_i = 1'b1;
                end
            end
            IBUSY, DBUSY: begin
                if (mem_resp_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (grant_d) begin
            if (imem_valid_i) starve_d = (starve_q == LIMIT) ? starve_q : starve_q + 4'd1;
            else              starve_d = 4'd0;
        end else if (grant_i) begin
            starve_d = 4'd0;
        end
        // A dropped fetch still completes on the port, but its response is swallowed.
        if (state_q == IBUSY && state_d == IBUSY) abort_d = abort_q | ~imem_valid_i;
        mem_valid_d = grant_i | grant_d | (mem_valid_q & ~mem_resp_i);
    end

    // Control state registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            starve_q    <= 4'd0;
            abort_q     <= 1'b0;
            mem_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            abort_q     <= abort_d;
            mem_valid_q <= mem_valid_d;
        end
    end

    // Request holding registers, loaded only on grant so the port is stable while busy.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            addr_q  <= '0;
            wdata_q <= '0;
            mask_q  <= '0;
            we_q    <= 1'b0;
        end else if (grant_d) begin
            addr_q  <= dmem_addr_i;
            wdata_q <= dmem_wdata_i;
            mask_q  <= dmem_mask_i;
            we_q    <= dmem_we_i;
        end else if (grant_i) begin
            addr_q  <= imem_addr_i;
            wdata_q <= '0;
            mask_q  <= '1;
            we_q    <= 1'b0;
        end
    end

    assign mem_addr_o   = addr_q;
    assign mem_wdata_o  = wdata_q;
    assign mem_mask_o   = mask_q;
    assign mem_we_o     = we_q;
    assign mem_valid_o  = mem_valid_q;

    assign imem_rdata_o = mem_rdata_i;
    assign dmem_rdata_o = mem_rdata_i;
    assign dmem_resp_o  = mem_resp_i & (state_q == DBUSY);
    assign imem_resp_o  = mem_resp_i & (state_q == IBUSY) & ~abort_q & imem_valid_i;

endmodule

// File: tb/tb_orion_mem_arbiter.sv
// Directed testbench for orion_mem_arbiter.
module tb_orion_mem_arbiter;
    import orion_types::*;

    logic             clk_i = 1'b0;
    logic             rst_ni;
    logic [ADDRW-1:0] imem_addr_i;
    logic             imem_valid_i;
    logic [XLEN-1:0]  imem_rdata_o;
    logic             imem_resp_o;
    logic [ADDRW-1:0] dmem_addr_i;
    logic [XLEN-1:0]  dmem_wdata_i;
    logic [MASKW-1:0] dmem_mask_i;
    logic             dmem_we_i;
    logic             dmem_valid_i;
    logic [XLEN-1:0]  dmem_rdata_o;
    logic             dmem_resp_o;
    logic [ADDRW-1:0] mem_addr_o;
    logic [XLEN-1:0]  mem_wdata_o;
    logic [MASKW-1:0] mem_mask_o;
    logic             mem_we_o;
    logic             mem_valid_o;
    logic [XLEN-1:0]  mem_rdata_i;
    logic             mem_resp_i;

    int total = 0;
    int bad   = 0;

    orion_mem_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .imem_addr_i(imem_addr_i), .imem_valid_i(imem_valid_i),
        .imem_rdata_o(imem_rdata_o), .imem_resp_o(imem_resp_o),
        .dmem_addr_i(dmem_addr_i), .dmem_wdata_i(dmem_wdata_i),
        .dmem_mask_i(dmem_mask_i), .dmem_we_i(dmem_we_i),
        .dmem_valid_i(dmem_valid_i), .dmem_rdata_o(dmem_rdata_o),
        .dmem_resp_o(dmem_resp_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_mask_o(mem_mask_o), .mem_we_o(mem_we_o),
        .mem_valid_o(mem_valid_o), .mem_rdata_i(mem_rdata_i),
        .mem_resp_i(mem_resp_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        imem_addr_i = '0; imem_valid_i = 1'b0;
        dmem_addr_i = '0; dmem_wdata_i = '0; dmem_mask_i = '0; dmem_we_i = 1'b0; dmem_valid_i = 1'b0;
        mem_rdata_i = '0; mem_resp_i = 1'b0;
        #3;
        total++;
        if (mem_valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b exp=0", mem_valid_o); end
        total++;
        if ({mem_addr_o, mem_wdata_o, mem_mask_o, mem_we_o} !== '0) begin
            bad++; $display("FAIL reset_fields addr=%h wdata=%h mask=%h we=%0b exp=0", mem_addr_o, mem_wdata_o, mem_mask_o, mem_we_o);
        end
        total++;
        if ({imem_resp_o, dmem_resp_o} !== 2'b00) begin bad++; $display("FAIL reset_resp got=%b exp=00", {imem_resp_o, dmem_resp_o}); end
        step(); step();
        rst_ni = 1'b1;
        step();
    endtask

    task automatic test_dmem_read();
        dmem_valid_i = 1'b1; dmem_we_i = 1'b0; dmem_addr_i = 32'h100; dmem_mask_i = 4'hF;
        step();
        total++;
        if (mem_valid_o !== 1'b1 || mem_addr_o !== 32'h100 || mem_we_o !== 1'b0) begin
            bad++; $display("FAIL read_issue valid=%0b addr=%h we=%0b exp 1/100/0", mem_valid_o, mem_addr_o, mem_we_o);
        end
        step(); step();
        mem_resp_i = 1'b1; mem_rdata_i = 32'hDEADBEEF;
        #1;
        total++;
        if (dmem_resp_o !== 1'b1 || imem_resp_o !== 1'b0) begin
            bad++; $display("FAIL read_resp dmem=%0b imem=%0b exp 1/0", dmem_resp_o, imem_resp_o);
        end
        total++;
        if (dmem_rdata_o !== 32'hDEADBEEF || imem_rdata_o !== 32'hDEADBEEF) begin
            bad++; $display("FAIL read_rdata d=%h i=%h exp deadbeef", dmem_rdata_o, imem_rdata_o);
        end
        step();
        mem_resp_i = 1'b0; dmem_valid_i = 1'b0;
        #1;
        total++;
        if (dmem_resp_o !== 1'b0 || mem_valid_o !== 1'b0) begin
            bad++; $display("FAIL read_after resp=%0b valid=%0b exp 0/0", dmem_resp_o, mem_valid_o);
        end
        step();
    endtask

    task automatic test_starve();
        string seq = "";
        int n = 0;
        logic drop_i = 1'b0;
        imem_valid_i = 1'b1; imem_addr_i = 32'h80;
        dmem_valid_i = 1'b1; dmem_we_i = 1'b1; dmem_addr_i = 32'h180; dmem_wdata_i = 32'hA5A5A5A5; dmem_mask_i = 4'h5;
        for (int c = 0; c < 40 && n < 5; c++) begin
            step();
            mem_resp_i = 1'b0;
            if (drop_i) imem_valid_i = 1'b0;
            if (mem_valid_o) begin
                mem_resp_i = 1'b1;
                mem_rdata_i = 32'h1000 + n;
                #1;
                if (dmem_resp_o && !imem_resp_o) seq = {seq, "D"};
                else if (imem_resp_o && !dmem_resp_o) begin
                    seq = {seq, "I"};
                    total++;
                    if (mem_addr_o !== 32'h80 || mem_we_o !== 1'b0 || mem_mask_o !== 4'hF || mem_wdata_o !== 32'h0) begin
                        bad++; $display("FAIL starve_ifields addr=%h we=%0b mask=%h wdata=%h exp 80/0/f/0", mem_addr_o, mem_we_o, mem_mask_o, mem_wdata_o);
                    end
                    drop_i = 1'b1;
                end else seq = {seq, "X"};
                n++;
            end
        end
        total++;
        if (seq != "DDDDI") begin bad++; $display("FAIL starve_order got=%s exp=DDDDI", seq); end
        step();
        mem_resp_i = 1'b0; imem_valid_i = 1'b0; dmem_valid_i = 1'b0; dmem_we_i = 1'b0;
        step();
    endtask

    task automatic test_flush();
        imem_valid_i = 1'b1; imem_addr_i = 32'h40;
        step();
        imem_valid_i = 1'b0;
        dmem_valid_i = 1'b1; dmem_addr_i = 32'h500; dmem_we_i = 1'b0;
        step(); step();
        mem_resp_i = 1'b1; mem_rdata_i = 32'h55;
        #1;
        total++;
        if (imem_resp_o !== 1'b0 || dmem_resp_o !== 1'b0 || mem_addr_o !== 32'h40) begin
            bad++; $display("FAIL flush_resp imem=%0b dmem=%0b addr=%h exp 0/0/40", imem_resp_o, dmem_resp_o, mem_addr_o);
        end
        step();
        mem_resp_i = 1'b0;
        step();
        total++;
        if (mem_valid_o !== 1'b1 || mem_addr_o !== 32'h500) begin
            bad++; $display("FAIL flush_next_d valid=%0b addr=%h exp 1/500", mem_valid_o, mem_addr_o);
        end
        mem_resp_i = 1'b1;
        #1;
        total++;
        if (dmem_resp_o !== 1'b1 || imem_resp_o !== 1'b0) begin
            bad++; $display("FAIL flush_d_resp dmem=%0b imem=%0b exp 1/0", dmem_resp_o, imem_resp_o);
        end
        step();
        mem_resp_i = 1'b0; dmem_valid_i = 1'b0;
        step();
    endtask

    task automatic test_hold_fields();
        dmem_valid_i = 1'b1; dmem_we_i = 1'b1; dmem_addr_i = 32'h200; dmem_wdata_i = 32'h12345678; dmem_mask_i = 4'b0011;
        step();
        dmem_addr_i = 32'h300; dmem_wdata_i = 32'hFFFF0000; dmem_mask_i = 4'hF; dmem_we_i = 1'b0;
        step();
        total++;
        if (mem_addr_o !== 32'h200 || mem_we_o !== 1'b1 || mem_mask_o !== 4'b0011 || mem_wdata_o !== 32'h12345678) begin
            bad++; $display("FAIL hold_fields addr=%h we=%0b mask=%b wdata=%h exp 200/1/0011/12345678", mem_addr_o, mem_we_o, mem_mask_o, mem_wdata_o);
        end
        mem_resp_i = 1'b1;
        step();
        mem_resp_i = 1'b0; dmem_valid_i = 1'b0;
        step();
    endtask

    task automatic test_back_to_back();
        dmem_valid_i = 1'b1; dmem_we_i = 1'b0; dmem_addr_i = 32'h700;
        step();
        mem_resp_i = 1'b1;
        step();
        mem_resp_i = 1'b0;
        dmem_addr_i = 32'h704;
        total++;
        if (mem_valid_o !== 1'b0) begin bad++; $display("FAIL b2b_gap valid=%0b exp=0", mem_valid_o); end
        step();
        total++;
        if (mem_valid_o !== 1'b1 || mem_addr_o !== 32'h704) begin
            bad++; $display("FAIL b2b_regrant valid=%0b addr=%h exp 1/704", mem_valid_o, mem_addr_o);
        end
        mem_resp_i = 1'b1;
        #1;
        total++;
        if (dmem_resp_o !== 1'b1) begin bad++; $display("FAIL b2b_resp got=%0b exp=1", dmem_resp_o); end
        step();
        mem_resp_i = 1'b0; dmem_valid_i = 1'b0;
        step();
    endtask

    task automatic test_reset_mid();
        dmem_valid_i = 1'b1; dmem_we_i = 1'b1; dmem_addr_i = 32'h600; dmem_wdata_i = 32'h77; dmem_mask_i = 4'hF;
        step();
        #2;
        rst_ni = 1'b0;
        #1;
        total++;
        if (mem_valid_o !== 1'b0 || mem_addr_o !== '0 || mem_we_o !== 1'b0) begin
            bad++; $display("FAIL rst_async valid=%0b addr=%h we=%0b exp 0/0/0", mem_valid_o, mem_addr_o, mem_we_o);
        end
        dmem_valid_i = 1'b0;
        step();
        rst_ni = 1'b1;
        step();
        mem_resp_i = 1'b1;
        #1;
        total++;
        if (dmem_resp_o !== 1'b0 || imem_resp_o !== 1'b0) begin
            bad++; $display("FAIL rst_no_resp dmem=%0b imem=%0b exp 0/0", dmem_resp_o, imem_resp_o);
        end
        step();
        mem_resp_i = 1'b0;
        total++;
        if (dut.state_q !== IDLE || mem_valid_o !== 1'b0) begin
            bad++; $display("FAIL rst_idle state=%0d valid=%0b exp 0/0", dut.state_q, mem_valid_o);
        end
    endtask

    task automatic test_idle_resp();
        step();
        mem_resp_i = 1'b1;
        #1;
        total++;
        if (dmem_resp_o !== 1'b0 || imem_resp_o !== 1'b0) begin
            bad++; $display("FAIL idle_resp dmem=%0b imem=%0b exp 0/0", dmem_resp_o, imem_resp_o);
        end
        step();
        mem_resp_i = 1'b0;
        total++;
        if (dut.state_q !== IDLE || mem_valid_o !== 1'b0) begin
            bad++; $display("FAIL idle_state state=%0d valid=%0b exp 0/0", dut.state_q, mem_valid_o);
        end
    endtask

    initial begin
        test_reset();
        test_dmem_read();
        test_starve();
        test_flush();
        test_hold_fields();
        test_back_to_back();
        test_reset_mid();
        test_idle_resp();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
